// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store width
// codes and the responder FSM state type.
package dmem_pkg;

    // Load width/sign codes
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store width codes
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the data-memory responder. Stores: lane strobes and
// the data shifted into its lanes. Loads: the addressed bytes shifted down and
// sign- or zero-extended. Illegal width codes and misalignment raise fmt_err_o,
// which also forces the strobes and load data to zero.
module dmem_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        fmt_err_o
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    // Decode width code, build strobes / shifted store data / extended load data
    always_comb begin
        shamt     = {addr_lo_i, 3'b000};
        rshift    = rword_i >> shamt;
        wdata_o   = wdata_i << shamt;
        be_o      = 4'b0000;
        rdata_o   = 32'h0;
        fmt_err_o = 1'b0;
        if (we_i) begin
            case (funct3_i)
                F3_SB: be_o = 4'b0001 << addr_lo_i;
                F3_SH: begin
                    be_o      = 4'b0011 << addr_lo_i;
                    fmt_err_o = addr_lo_i[0];
                end
                F3_SW: begin
                    be_o      = 4'b1111;
                    fmt_err_o = |addr_lo_i;
                end
                default: fmt_err_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_LB:  rdata_o = {{24{rshift[7]}}, rshift[7:0]};
                F3_LH: begin
                    rdata_o   = {{16{rshift[15]}}, rshift[15:0]};
                    fmt_err_o = addr_lo_i[0];
                end
                F3_LW: begin
                    rdata_o   = rshift;
                    fmt_err_o = |addr_lo_i;
                end
                F3_LBU: rdata_o = {24'h0, rshift[7:0]};
                F3_LHU: begin
                    rdata_o   = {16'h0, rshift[15:0]};
                    fmt_err_o = addr_lo_i[0];
                end
                default: fmt_err_o = 1'b1;
            endcase
        end
        if (fmt_err_o) begin
            be_o    = 4'b0000;
            rdata_o = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder. A request is captured in IDLE,
// waits LATENCY cycles in BUSY, then performs the store commit / load read on
// the BUSY->RESP edge and holds the response until the requester takes it.
//
// state | meaning
// IDLE  | ready for a request (req_ready = 1)
// BUSY  | access in flight, down-counter running to zero
// RESP  | response presented, waiting for rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // BUSY lasts LATENCY cycles: load LATENCY-1 and leave when the count hits zero
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             busy_done;
    logic             range_err;
    logic             fmt_err;
    logic             acc_err;
    logic             commit;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rdata_ext;
    logic [31:0]      rword;

    assign idx       = addr_q[IDX_W+1:2];
    assign range_err = (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign acc_err   = range_err | fmt_err;
    assign busy_done = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign commit    = busy_done && we_q && !acc_err;
    assign rword     = mem_q[idx];

    dmem_align u_align (
        .we_i      (we_q),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .wdata_i   (wdata_q),
        .rword_i   (rword),
        .be_o      (be),
        .wdata_o   (wdata_sh),
        .rdata_o   (rdata_ext),
        .fmt_err_o (fmt_err)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)           state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == 4'd0)    state_d = ST_RESP;
            ST_RESP: if (rsp_ready)        state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake signals decoded from the current state
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        accept    = req_valid && req_ready;
    end

    // BUSY down-counter and response data next-state
    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d = CNT_LOAD;
        end else if ((state_q == ST_BUSY) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (busy_done) begin
            rdata_d = (we_q || acc_err) ? 32'h0 : rdata_ext;
            err_d   = acc_err;
        end
    end

    // Counter, captured request and held response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
        end
    end

    // Storage: per-byte write on the BUSY->RESP edge, contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-level reference model that is
// compared against the handshake and response outputs on every cycle.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  mem_m [DEPTH*4];
    bit          m_live = 0;
    bit          m_out  = 0;
    int          cyc    = 0;
    int          m_acc  = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic        m_err;
    int          m_size;
    bit          exp_v;

    function automatic void model_eval(input logic we, input logic [31:0] a,
                                       input logic [2:0] f3, output logic [31:0] rd,
                                       output logic err, output int size);
        bit legal = 1;
        bit sgn   = 0;
        size = 4;
        if (we) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: legal = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: legal = 0;
            endcase
        end
        err = !legal || (int'(a[1:0]) % size != 0) || (a[31:2] >= 30'(DEPTH));
        rd  = 32'h0;
        if (!err && !we) begin
            for (int i = size - 1; i >= 0; i--) rd = (rd << 8) | 32'(mem_m[int'(a) + i]);
            if (sgn && size == 1 && rd[7])  rd[31:8]  = 24'hFFFFFF;
            if (sgn && size == 2 && rd[15]) rd[31:16] = 16'hFFFF;
        end
    endfunction

    // Model transitions: reset abort, response handshake (store commit), acceptance
    always @(posedge clk) begin
        if (rst) begin
            m_live = 1;
            m_out  = 0;
        end else if (m_live) begin
            if (m_out && (cyc - m_acc >= LAT + 1) && rsp_ready) begin
                if (m_we && !m_err)
                    for (int i = 0; i < m_size; i++) mem_m[int'(m_addr) + i] = 8'(m_wdata >> (8*i));
                m_out = 0;
            end else if (!m_out && req_valid) begin
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                model_eval(req_we, req_addr, req_funct3, m_rd, m_err, m_size);
                m_acc = cyc;
                m_out = 1;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            exp_v = m_out && (cyc - m_acc >= LAT + 1);
            tests++;
            if (req_ready !== !m_out || rsp_valid !== exp_v ||
                (exp_v && (rsp_rdata !== m_rd || rsp_err !== m_err))) begin
                fails++;
                $display("FAIL model cyc=%0d: ready=%b want %b valid=%b want %b rdata=%h want %h err=%b want %b",
                         cyc, req_ready, !m_out, rsp_valid, exp_v, rsp_rdata, m_rd, rsp_err, m_err);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
        int n = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL accept timeout: req_ready %b expected 1", req_ready);
        end
        @(posedge clk); #1;
        // scramble inputs after acceptance; the access must not see them
        req_valid = 0; req_we = ~we; req_addr = ~a; req_wdata = ~wd; req_funct3 = ~f3;
    endtask

    task automatic wait_rsp(input string name, input logic [31:0] exp_rd, input logic exp_e);
        int n = 1;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check({name, " latency"}, 32'(n), 32'(LAT + 1));
        check({name, " rdata"}, rsp_rdata, exp_rd);
        check({name, " err"}, 32'(rsp_err), 32'(exp_e));
    endtask

    task automatic handshake();
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic access(input string name, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_e);
        issue(we, a, wd, f3);
        wait_rsp(name, exp_rd, exp_e);
        handshake();
    endtask

    initial begin
        for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset req_ready", 32'(req_ready), 1);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_err", 32'(rsp_err), 0);
        rst = 0;

        access("sw10",      1, 32'h10, 32'hDEADBEEF, F3_SW, 32'h0, 0);
        access("lw10",      0, 32'h10, 32'h0, F3_LW, 32'hDEADBEEF, 0);
        access("sb11",      1, 32'h11, 32'h0000007F, F3_SB, 32'h0, 0);
        access("lw10 b",    0, 32'h10, 32'h0, F3_LW, 32'hDEAD7FEF, 0);
        access("lb13",      0, 32'h13, 32'h0, F3_LB, 32'hFFFFFFDE, 0);
        access("lbu13",     0, 32'h13, 32'h0, F3_LBU, 32'h000000DE, 0);
        access("lh12",      0, 32'h12, 32'h0, F3_LH, 32'hFFFFDEAD, 0);
        access("lhu12",     0, 32'h12, 32'h0, F3_LHU, 32'h0000DEAD, 0);
        access("lb11",      0, 32'h11, 32'h0, F3_LB, 32'h0000007F, 0);
        access("lw12 mis",  0, 32'h12, 32'h0, F3_LW, 32'h0, 1);
        access("sw12 mis",  1, 32'h12, 32'h11111111, F3_SW, 32'h0, 1);
        access("sh11 mis",  1, 32'h11, 32'h00002222, F3_SH, 32'h0, 1);
        access("s f3=4",    1, 32'h10, 32'h33333333, 3'd4, 32'h0, 1);
        access("lw10 c",    0, 32'h10, 32'h0, F3_LW, 32'hDEAD7FEF, 0);
        access("lw oor",    0, 32'(DEPTH*4), 32'h0, F3_LW, 32'h0, 1);
        access("l f3=3",    0, 32'h10, 32'h0, 3'd3, 32'h0, 1);
        access("sh12",      1, 32'h12, 32'h0000BEEF, F3_SH, 32'h0, 0);
        access("lw10 d",    0, 32'h10, 32'h0, F3_LW, 32'hBEEF7FEF, 0);

        // stalled response, then a request waiting during the handshake cycle
        issue(1, 32'h20, 32'hCAFEF00D, F3_SW);
        wait_rsp("sw20 stall", 32'h0, 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("stall req_ready", 32'(req_ready), 0);
            check("stall rsp_valid", 32'(rsp_valid), 1);
        end
        req_valid = 1; req_we = 0; req_addr = 32'h20; req_wdata = 32'h0; req_funct3 = F3_LW;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("post-hs req_ready", 32'(req_ready), 1);
        check("post-hs rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        check("b2b accepted", 32'(req_ready), 0);
        req_valid = 0; req_addr = 32'hFFFFFFDF; req_we = 1; req_funct3 = 3'd7;
        wait_rsp("b2b lw20", 32'hCAFEF00D, 0);
        handshake();

        // reset during BUSY aborts the store
        issue(1, 32'h20, 32'h12345678, F3_SW);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("abort req_ready", 32'(req_ready), 1);
        check("abort rsp_valid", 32'(rsp_valid), 0);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort no rsp", 32'(rsp_valid), 0);
        end
        access("lw20 after abort", 0, 32'h20, 32'h0, F3_LW, 32'hCAFEF00D, 0);

        // reset during RESP drops the response and clears its data
        issue(0, 32'h10, 32'h0, F3_LW);
        wait_rsp("lw10 pre-rst", 32'hBEEF7FEF, 0);
        rst = 1; rsp_ready = 1;
        @(posedge clk); #1;
        rst = 0; rsp_ready = 0;
        check("resp-rst rsp_valid", 32'(rsp_valid), 0);
        check("resp-rst rsp_rdata", rsp_rdata, 0);
        check("resp-rst req_ready", 32'(req_ready), 1);
        access("lw10 after rst", 0, 32'h10, 32'h0, F3_LW, 32'hBEEF7FEF, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2: BUSY cycles per access, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: request present.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port req_funct3, input, 3: RV32I width/sign code.
REQ-011 SHALL have port rsp_valid, output, 1: response present.
REQ-012 SHALL have port rsp_ready, input, 1: requester takes the response.
REQ-013 SHALL have port rsp_rdata, output, 32: extended load data, 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1: access faulted.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-016 SHALL drive req_ready high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-017 SHALL capture we, addr, wdata and funct3 on acceptance; later input changes SHALL NOT affect the access.
REQ-018 SHALL stay in BUSY for exactly LATENCY cycles using a 4-bit counter, then enter RESP.
REQ-019 SHALL assert rsp_valid first in the cycle LATENCY+1 cycles after the accepting edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready high, then return to IDLE.
REQ-021 SHALL allow a new request to be accepted one cycle after the response handshake, with no back-to-back acceptance in RESP.
REQ-022 SHALL decode load funct3 as 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, and store funct3 as 0 SB, 1 SH, 2 SW; any other code SHALL give err.
REQ-023 SHALL give err for a misaligned halfword (addr[0]=1) or word (addr[1:0]!=0).
REQ-024 SHALL give err for out-of-range addresses, addr[31:2] >= DEPTH_WORDS.
REQ-025 SHALL commit stores on the BUSY->RESP edge, writing only the byte lanes selected by addr[1:0] and the width.
REQ-026 SHALL perform no write when err is set, and SHALL return rsp_rdata = 0.
REQ-027 SHALL read loads on the BUSY->RESP edge, then shift by addr[1:0] and sign- or zero-extend per funct3.

Reset
REQ-028 SHALL, on rst, set state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and req_ready 1 in the next cycle.
REQ-029 SHALL abort any access when rst is asserted in BUSY or RESP: no store commit and no response.
REQ-030 SHALL NOT reset storage contents.
REQ-031 SHALL give rst priority over a simultaneous req_valid or rsp_ready.

Structure
REQ-032 SHALL place in shared package dmem_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state type.
REQ-033 SHALL use one combinational sub-module, dmem_align, for the lane-strobe/store-shift and load-extract/extend logic.
REQ-034 SHALL infer storage as a single DEPTH_WORDS x 32 array with per-byte write enables.

Verification
REQ-035 SHALL cover SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid at accept+3 (LATENCY=2).
REQ-036 SHALL cover, after REQ-035, SB addr 0x11 data 0x7F then LW 0x10 -> 0xDEAD7FEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
REQ-037 SHALL cover LH at 0x12 -> 0xFFFFDEAD, and LW at 0x12 -> rsp_err 1, rdata 0; SW at 0x12 -> err with no memory change.
REQ-038 SHALL cover LW at DEPTH_WORDS*4 -> err; funct3 3 load -> err.
REQ-039 SHALL cover rsp_ready held low 5 cycles -> response stable and req_ready 0 throughout; request accepted the cycle after the handshake.
REQ-040 SHALL cover rst asserted during BUSY of SW 0x20 data 0x12345678 -> no rsp_valid, and a following LW 0x20 returns the prior contents.
